// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift, rotate, arithmetic shift, load and clear,
// with a serial-out bit and a frame pulse after every WIDTH shift/rotate operations.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_lsb_i,
  input  logic             ser_msb_i,
  input  logic [WIDTH-1:0] load_i,
  output logic [WIDTH-1:0] sr_o,
  output logic             ser_o,
  output logic [CW-1:0]    cnt_o,
  output logic             frame_o
);

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROTL  = 3'd3;
  localparam logic [2:0] MODE_ROTR  = 3'd4;
  localparam logic [2:0] MODE_ASR   = 3'd5;
  localparam logic [2:0] MODE_LOAD  = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic             r_ser;
  logic [CW-1:0]    r_cnt;
  logic             r_frame;

  logic [WIDTH-1:0] w_sr_next;
  logic             w_ser_next;
  logic             w_counting;
  logic             w_cnt_clear;

  always_comb begin
    w_sr_next   = r_sr;
    w_ser_next  = r_ser;
    w_counting  = 1'b0;
    w_cnt_clear = 1'b0;
    case (mode_i)
      MODE_HOLD: begin
        w_sr_next = r_sr;
      end
      MODE_SHL: begin
        w_sr_next  = {r_sr[WIDTH-2:0], ser_lsb_i};
        w_ser_next = r_sr[WIDTH-1];
        w_counting = 1'b1;
      end
      MODE_SHR: begin
        w_sr_next  = {ser_msb_i, r_sr[WIDTH-1:1]};
        w_ser_next = r_sr[0];
        w_counting = 1'b1;
      end
      MODE_ROTL: begin
        w_sr_next  = {r_sr[WIDTH-2:0], r_sr[WIDTH-1]};
        w_ser_next = r_sr[WIDTH-1];
        w_counting = 1'b1;
      end
      MODE_ROTR: begin
        w_sr_next  = {r_sr[0], r_sr[WIDTH-1:1]};
        w_ser_next = r_sr[0];
        w_counting = 1'b1;
      end
      MODE_ASR: begin
        w_sr_next  = {r_sr[WIDTH-1], r_sr[WIDTH-1:1]};
        w_ser_next = r_sr[0];
        w_counting = 1'b1;
      end
      MODE_LOAD: begin
        w_sr_next   = load_i;
        w_ser_next  = 1'b0;
        w_cnt_clear = 1'b1;
      end
      MODE_CLEAR: begin
        w_sr_next   = '0;
        w_ser_next  = 1'b0;
        w_cnt_clear = 1'b1;
      end
      default: begin
        w_sr_next = r_sr;
      end
    endcase
  end

  // frame defaults low every cycle so it can only ever be a single-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sr    <= '0;
      r_ser   <= 1'b0;
      r_cnt   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (en_i) begin
        r_sr  <= w_sr_next;
        r_ser <= w_ser_next;
        if (w_cnt_clear) begin
          r_cnt <= '0;
        end else if (w_counting) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_frame <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign sr_o    = r_sr;
  assign ser_o   = r_ser;
  assign cnt_o   = r_cnt;
  assign frame_o = r_frame;

endmodule
